// File: rtl/rob_pkg.sv
// rob_pkg: shared sizes, state encoding, pointer type and
// popcount helper for the ROB dispatch/recovery controller.
package rob_pkg;

    localparam int DEPTH = 128;
    localparam int IDX_W = 7;
    localparam int WIDTH = 4;

    typedef logic [IDX_W:0] rob_ptr_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WALK   = 2'd1,
        RESUME = 2'd2
    } rob_ctrl_state_e;

    function automatic logic [2:0] popcnt4(input logic [3:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]}
             + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

endpackage

// File: rtl/rob_occ_counter.sv
// rob_occ_counter: registered ROB occupancy with full/empty flags.
// In: clk, reset, add_cnt, sub_cnt, load_en, load_val.
// Out: occupancy, full, empty.
module rob_occ_counter
    import rob_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     add_cnt,
    input  logic [2:0]     sub_cnt,
    input  logic           load_en,
    input  logic [IDX_W:0] load_val,
    output logic [IDX_W:0] occupancy,
    output logic           full,
    output logic           empty
);

    localparam logic [IDX_W:0] FULL_TH = (IDX_W+1)'(DEPTH - WIDTH);

    logic [IDX_W:0] base;
    logic [IDX_W:0] occ_nxt;

    // A tail rewind replaces the count; retirements still net against it.
    always_comb begin
        base    = load_en ? load_val : occupancy;
        occ_nxt = base + (IDX_W+1)'(add_cnt) - (IDX_W+1)'(sub_cnt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            occupancy <= occ_nxt;
            full      <= occ_nxt > FULL_TH;
            empty     <= occ_nxt == '0;
        end
    end

endmodule

// File: rtl/rob_dispatch_ctrl.sv
// rob_dispatch_ctrl: ROB allocation, head/tail tracking and flush walk.
// In: clk, reset, dec_valid, dec_mask, head_adv, exception_valid/idx.
// Out: dec_ready, rob_inserted, alloc_base, flush_valid/idx,
//      recover_busy, occupancy, full, empty.
module rob_dispatch_ctrl
    import rob_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [WIDTH-1:0] dec_mask,
    output logic             dec_ready,
    output logic [WIDTH-1:0] rob_inserted,
    output logic [IDX_W-1:0] alloc_base,
    input  logic [2:0]       head_adv,
    input  logic             exception_valid,
    input  logic [IDX_W-1:0] exception_idx,
    output logic             flush_valid,
    output logic [IDX_W-1:0] flush_idx,
    output logic             recover_busy,
    output logic [IDX_W:0]   occupancy,
    output logic             full,
    output logic             empty
);

    rob_ctrl_state_e  state;
    rob_ptr_t         head_ptr;
    rob_ptr_t         tail_ptr;
    rob_ptr_t         walk_ptr;
    logic [IDX_W-1:0] exc_idx_q;

    logic             fire;
    logic             load_en;
    logic             exc_ok;
    logic [2:0]       add_cnt;
    logic [2:0]       sub_cnt;
    logic [IDX_W-1:0] exc_next;
    rob_ptr_t         tail_fire;
    rob_ptr_t         walk_start;
    rob_ptr_t         rewind_ptr;
    rob_ptr_t         rewind_occ;
    rob_ptr_t         avail;
    rob_ptr_t         exc_off;

    assign dec_ready    = (state == RUN) & ~full & reset;
    assign fire         = dec_valid & dec_ready;
    assign rob_inserted = fire ? dec_mask : '0;
    assign alloc_base   = tail_ptr[IDX_W-1:0];
    assign recover_busy = state != RUN;
    assign flush_valid  = state == WALK;
    assign flush_idx    = (state == WALK) ? walk_ptr[IDX_W-1:0] : '0;

    always_comb begin
        add_cnt    = fire ? popcnt4(dec_mask) : 3'd0;
        tail_fire  = tail_ptr + rob_ptr_t'(add_cnt);
        walk_start = tail_fire - rob_ptr_t'(1);
        // walk_ptr holds the excepting entry's full pointer in RESUME,
        // so the rewound tail keeps a wrap bit consistent with head.
        rewind_ptr = walk_ptr + rob_ptr_t'(1);
        rewind_occ = rewind_ptr - head_ptr;
        load_en    = state == RESUME;
        avail      = load_en ? rewind_occ : occupancy;
        sub_cnt    = (rob_ptr_t'(head_adv) > avail) ? avail[2:0]
                                                    : head_adv;
        exc_off    = {1'b0, exception_idx - head_ptr[IDX_W-1:0]};
        exc_ok     = (state == RUN) & exception_valid
                   & (exc_off < occupancy);
        exc_next   = exc_idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            walk_ptr  <= '0;
            exc_idx_q <= '0;
        end else begin
            head_ptr <= head_ptr + rob_ptr_t'(sub_cnt);
            unique case (state)
                RUN: begin
                    tail_ptr <= tail_fire;
                    if (exc_ok) begin
                        walk_ptr  <= walk_start;
                        exc_idx_q <= exception_idx;
                        if (walk_start[IDX_W-1:0] == exception_idx)
                            state <= RESUME;
                        else
                            state <= WALK;
                    end
                end
                WALK: begin
                    walk_ptr <= walk_ptr - rob_ptr_t'(1);
                    if (walk_ptr[IDX_W-1:0] == exc_next)
                        state <= RESUME;
                end
                RESUME: begin
                    tail_ptr <= rewind_ptr;
                    state    <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    rob_occ_counter u_occ (
        .clk       (clk),
        .reset     (reset),
        .add_cnt   (add_cnt),
        .sub_cnt   (sub_cnt),
        .load_en   (load_en),
        .load_val  (rewind_occ),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_rob_dispatch_ctrl.sv
// tb_rob_dispatch_ctrl: directed stimulus, queue-based reference
// model compared every cycle, plus literal expectations.
module tb_rob_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic [3:0] dec_mask;
    logic       dec_ready;
    logic [3:0] rob_inserted;
    logic [6:0] alloc_base;
    logic [2:0] head_adv;
    logic       exception_valid;
    logic [6:0] exception_idx;
    logic       flush_valid;
    logic [6:0] flush_idx;
    logic       recover_busy;
    logic [7:0] occupancy;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    rob_dispatch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .dec_valid       (dec_valid),
        .dec_mask        (dec_mask),
        .dec_ready       (dec_ready),
        .rob_inserted    (rob_inserted),
        .alloc_base      (alloc_base),
        .head_adv        (head_adv),
        .exception_valid (exception_valid),
        .exception_idx   (exception_idx),
        .flush_valid     (flush_valid),
        .flush_idx       (flush_idx),
        .recover_busy    (recover_busy),
        .occupancy       (occupancy),
        .full            (full),
        .empty           (empty)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     n, act, exp, $time);
        end
    endtask

    // Reference model: unbounded entry counts; recovery is a queue of
    // pending cycles (flush index, or -1 for the tail-rewind cycle).
    int m_head = 0;
    int m_tail = 0;
    int m_exc  = 0;
    int q[$];
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        int occ, off, t2, adv;
        bit rdy;
        if (!reset) begin
            m_head = 0;
            m_tail = 0;
            q.delete();
            chk_en = 1'b1;
        end else if (chk_en) begin
            occ = m_tail - m_head;
            rdy = (q.size() == 0) && (occ <= 124);
            t2  = m_tail;
            if (dec_valid && rdy)
                t2 += $countones(dec_mask);
            if (q.size() > 0) begin
                if (q[0] < 0)
                    t2 = m_exc + 1;
                void'(q.pop_front());
            end else if (exception_valid) begin
                off = (int'(exception_idx) - (m_head % 128) + 128) % 128;
                if (off < occ) begin
                    m_exc = m_head + off;
                    for (int c = t2 - 1; c > m_exc; c--)
                        q.push_back(c % 128);
                    q.push_back(-1);
                end
            end
            adv = int'(head_adv);
            cmp("head_adv_legal", adv > t2 - m_head, 0);
            if (adv > t2 - m_head)
                adv = t2 - m_head;
            m_tail = t2;
            m_head += adv;
        end
    end

    always @(negedge clk) begin
        int occ, fidx;
        bit busy, rdy, fv;
        if (chk_en) begin
            occ  = m_tail - m_head;
            busy = q.size() > 0;
            rdy  = reset && !busy && (occ <= 124);
            fv   = 1'b0;
            fidx = 0;
            if (busy && q[0] >= 0) begin
                fv   = 1'b1;
                fidx = q[0];
            end
            cmp("m_dec_ready", dec_ready, rdy);
            cmp("m_rob_inserted", rob_inserted,
                (dec_valid && rdy) ? dec_mask : 4'd0);
            cmp("m_alloc_base", alloc_base, m_tail % 128);
            cmp("m_occupancy", occupancy, occ);
            cmp("m_full", full, occ > 124);
            cmp("m_empty", empty, occ == 0);
            cmp("m_recover_busy", recover_busy, busy);
            cmp("m_flush_valid", flush_valid, fv);
            cmp("m_flush_idx", flush_idx, fidx);
        end
    end

    task automatic drv(input bit v, input logic [3:0] m,
                       input logic [2:0] a, input bit ev,
                       input logic [6:0] ei);
        dec_valid       = v;
        dec_mask        = m;
        head_adv        = a;
        exception_valid = ev;
        exception_idx   = ei;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 4'b0001, 3'd0, 1'b0, 7'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_flush1[4];
        int exp_flush2[3];
        exp_flush1 = '{19, 18, 17, 16};
        exp_flush2 = '{1, 0, 127};
        reset = 1'b0;
        idle();
        tick();
        tick();
        #1;
        cmp("rst_occ", occupancy, 0);
        cmp("rst_empty", empty, 1);
        cmp("rst_full", full, 0);
        cmp("rst_ready", dec_ready, 0);
        cmp("rst_flush_valid", flush_valid, 0);
        cmp("rst_flush_idx", flush_idx, 0);
        cmp("rst_busy", recover_busy, 0);
        cmp("rst_alloc_base", alloc_base, 0);
        cmp("rst_inserted", rob_inserted, 0);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 4'b1111, 3'd0, 1'b0, 7'd0);
            #1;
            cmp("fill_base", alloc_base, i * 4);
            cmp("fill_ins", rob_inserted, 4'b1111);
            tick();
        end
        idle();
        #1;
        cmp("fill_occ16", occupancy, 16);

        drv(1'b0, 4'b0001, 3'd4, 1'b0, 7'd0);
        tick();
        drv(1'b0, 4'b0001, 3'd2, 1'b0, 7'd0);
        tick();
        drv(1'b1, 4'b0111, 3'd3, 1'b0, 7'd0);
        #1;
        cmp("net_base_before", alloc_base, 16);
        cmp("net_occ_before", occupancy, 10);
        tick();
        idle();
        #1;
        cmp("net_occ_after", occupancy, 10);
        cmp("net_base_after", alloc_base, 19);

        drv(1'b1, 4'b0001, 3'd0, 1'b0, 7'd0);
        tick();
        drv(1'b0, 4'b0001, 3'd0, 1'b1, 7'd15);
        #1;
        cmp("exc1_base", alloc_base, 20);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            cmp("walk1_valid", flush_valid, 1);
            cmp("walk1_idx", flush_idx, exp_flush1[i]);
            tick();
        end
        #1;
        cmp("resume1_valid", flush_valid, 0);
        cmp("resume1_busy", recover_busy, 1);
        cmp("resume1_ready", dec_ready, 0);
        tick();
        #1;
        cmp("run1_ready", dec_ready, 1);
        cmp("run1_base", alloc_base, 16);
        cmp("run1_occ", occupancy, 7);

        for (int i = 0; i < 29; i++) begin
            drv(1'b1, 4'b1111, 3'd0, 1'b0, 7'd0);
            tick();
        end
        drv(1'b1, 4'b0011, 3'd0, 1'b0, 7'd0);
        tick();
        drv(1'b1, 4'b1111, 3'd0, 1'b0, 7'd0);
        #1;
        cmp("full_occ", occupancy, 125);
        cmp("full_flag", full, 1);
        cmp("full_ready", dec_ready, 0);
        cmp("full_ins", rob_inserted, 0);
        tick();
        drv(1'b0, 4'b0001, 3'd2, 1'b0, 7'd0);
        tick();
        idle();
        #1;
        cmp("unfull_occ", occupancy, 123);
        cmp("unfull_flag", full, 0);
        cmp("unfull_ready", dec_ready, 1);

        for (int i = 0; i < 30; i++) begin
            drv(1'b0, 4'b0001, 3'd4, 1'b0, 7'd0);
            tick();
        end
        drv(1'b0, 4'b0001, 3'd3, 1'b0, 7'd0);
        tick();
        idle();
        #1;
        cmp("drain_empty", empty, 1);
        for (int i = 0; i < 31; i++) begin
            drv(1'b1, 4'b1111, 3'd0, 1'b0, 7'd0);
            tick();
        end
        idle();
        #1;
        cmp("wrap_base", alloc_base, 2);
        cmp("wrap_occ", occupancy, 124);
        cmp("wrap_full", full, 0);

        drv(1'b0, 4'b0001, 3'd0, 1'b1, 7'd126);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 1)
                drv(1'b0, 4'b0001, 3'd1, 1'b1, 7'd10);
            else
                idle();
            #1;
            cmp("walk2_valid", flush_valid, 1);
            cmp("walk2_idx", flush_idx, exp_flush2[i]);
            tick();
        end
        idle();
        #1;
        cmp("resume2_valid", flush_valid, 0);
        cmp("resume2_busy", recover_busy, 1);
        tick();
        #1;
        cmp("run2_base", alloc_base, 127);
        cmp("run2_busy", recover_busy, 0);
        cmp("run2_occ", occupancy, 120);

        drv(1'b0, 4'b0001, 3'd0, 1'b1, 7'd127);
        tick();
        idle();
        #1;
        cmp("oor_exc_busy", recover_busy, 0);

        drv(1'b0, 4'b0001, 3'd0, 1'b1, 7'd126);
        tick();
        idle();
        #1;
        cmp("k0_valid", flush_valid, 0);
        cmp("k0_busy", recover_busy, 1);
        cmp("k0_ready", dec_ready, 0);
        tick();
        #1;
        cmp("k0_ready_back", dec_ready, 1);
        cmp("k0_base", alloc_base, 127);

        drv(1'b0, 4'b0001, 3'd0, 1'b1, 7'd7);
        tick();
        idle();
        #1;
        cmp("rstw_first_idx", flush_idx, 126);
        tick();
        tick();
        reset = 1'b0;
        tick();
        #1;
        cmp("rstw_valid", flush_valid, 0);
        cmp("rstw_occ", occupancy, 0);
        cmp("rstw_busy", recover_busy, 0);
        cmp("rstw_base", alloc_base, 0);
        reset = 1'b1;
        drv(1'b1, 4'b0011, 3'd0, 1'b0, 7'd0);
        #1;
        cmp("post_ins", rob_inserted, 4'b0011);
        tick();
        idle();
        #1;
        cmp("post_occ", occupancy, 2);
        cmp("post_base", alloc_base, 2);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_dispatch_ctrl.md
# rob_dispatch_ctrl

Allocation and recovery controller in front of the 128-entry, 4-wide reorder buffer. It accepts decode bundles over a valid/ready handshake and drives the ROB insert mask. It tracks head and tail pointers, occupancy and full/empty state. On an exception it runs a youngest-first flush walk over the entries younger than the excepting one, then rewinds the tail and resumes dispatch.

## Interface
- `DEPTH`, 128, ROB entries; must be a power of two.
- `IDX_W`, 7, index width; equals log2(DEPTH).
- `WIDTH`, 4, insert/commit width.
- Reset is synchronous and active-low, on a single clock.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous active-low reset.
- `dec_valid` in 1: decode bundle present.
- `dec_mask` in WIDTH: slot valid mask; legal values 0001, 0011, 0111, 1111.
- `dec_ready` out 1: controller accepts a bundle this cycle.
- `rob_inserted` out WIDTH: insert mask to the ROB.
- `alloc_base` out IDX_W: ROB index of slot 0. Slot k uses (alloc_base+k) mod DEPTH.
- `head_adv` in 3: number of entries (0..4) the ROB head retired this cycle.
- `exception_valid` in 1: exception reported.
- `exception_idx` in IDX_W: ROB index of the excepting entry.
- `flush_valid` out 1: flush strobe to the ROB.
- `flush_idx` out IDX_W: entry to invalidate.
- `recover_busy` out 1: recovery in progress.
- `occupancy` out IDX_W+1: live entries, 0..DEPTH.
- `full` out 1: occupancy > DEPTH-WIDTH.
- `empty` out 1: occupancy == 0.

## Operation
- Pointers `head_ptr` and `tail_ptr` are IDX_W+1 bits wide, including a wrap bit. Occupancy = tail_ptr − head_ptr, modulo 2^(IDX_W+1).
- Handshake:
  - dec_ready = (state==RUN) & ~full & reset.
  - fire = dec_valid & dec_ready.
  - rob_inserted = fire ? dec_mask : 0.
  - alloc_base = tail_ptr[IDX_W-1:0].
- On fire, tail_ptr increases by popcount(dec_mask), 1..4. The same cycle, head_ptr increases by head_adv. When both happen together, occupancy nets the two.
- head_adv greater than occupancy is illegal. The RTL clamps the head advance so occupancy never goes below 0, and the bench flags an assertion.
- An exception is accepted only in RUN, and only when exception_idx lies in [head, tail) modulo DEPTH. Anything else is ignored, including exceptions raised during WALK or RESUME.
- FSM:
  - RUN: on an accepted exception, set walk_ptr = tail−1.
    - If walk_ptr == exception_idx, go to RESUME.
    - Otherwise go to WALK.
  - WALK: flush_valid=1, flush_idx=walk_ptr. walk_ptr decrements each cycle. When the flushed entry is exception_idx+1, go to RESUME.
  - RESUME: tail_ptr ← pointer of exception_idx + 1, with the wrap bit recomputed relative to head_ptr. Then go to RUN.
- recover_busy = (state != RUN).
- Commits (head_adv) continue to be applied in every state.
- The excepting entry itself stays allocated; the ROB retires it through head_adv.

## Timing
- Reset values:
  - state=RUN, head_ptr=tail_ptr=0, occupancy=0.
  - empty=1, full=0, dec_ready=0 while reset is low.
  - rob_inserted=0, alloc_base=0.
  - flush_valid=0, flush_idx=0, recover_busy=0.
- Reset asserted mid-walk aborts recovery and returns every value above to reset state on the next edge.
- dec_ready depends only on registered state. It never depends on dec_valid.
- occupancy, full and empty are registered and reflect the edge after fire or head_adv.
- Recovery of K younger entries:
  - Exception sampled at edge e.
  - flush_valid high for K cycles, from e+1 to e+K.
  - RESUME at e+K+1.
  - dec_ready can rise at e+K+2.
  - For K=0: RESUME at e+1, RUN at e+2.
- Wrap-around: indices wrap mod 128, and a walk crossing index 0 continues at 127.

## Structure
- Package `rob_pkg`:
  - DEPTH, IDX_W and WIDTH localparams.
  - `rob_ctrl_state_e` enum: RUN, WALK, RESUME.
  - `popcnt4` function.
  - Pointer typedef `rob_ptr_t`, IDX_W+1 bits.
- One sub-module, `rob_occ_counter`:
  - Inputs: add count, subtract count, tail-rewind load.
  - Outputs: occupancy, full, empty.

## Test plan
- Reset, then four fires with mask 1111 and head_adv=0 → alloc_base 0, 4, 8, 12; occupancy=16; rob_inserted=1111 on each fire cycle.
- Fill to occupancy 125 → full=1, dec_ready=0. One cycle with head_adv=2 → occupancy 123, full=0, dec_ready=1 on the next cycle.
- Same cycle: mask 0111 fire and head_adv=3 from occupancy 10 → occupancy stays 10; alloc_base advances by 3.
- Tail at 20, exception_idx=15 → flush_idx 19, 18, 17, 16 on consecutive cycles, then RESUME. alloc_base=16 and dec_ready=1 two cycles after the last flush.
- Tail at 2 after wrap, exception_idx=126 → flush_idx 1, 0, 127, then tail rewinds to 127. A second exception during the walk is ignored.
- Exception with exception_idx == tail−1 → no flush strobes; dec_ready returns 2 cycles after the exception. Reset asserted mid-walk → flush_valid=0 and occupancy=0 at the next edge.
